// File: rtl/int_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl_if
// Brief    : Configuration register port and INT/ack/eoi handshake bundle.
// Revision : 1.0
// ============================================================================
interface int_ctrl_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        INT;
    logic        int_ack;
    logic [31:0] int_vec;
    logic [3:0]  int_id;
    logic        eoi;

    // Controller side
    modport master (
        input  cfg_we, cfg_addr, cfg_wdata, int_ack, eoi,
        output cfg_rdata, INT, int_vec, int_id
    );

    // Processor / decode side
    modport slave (
        output cfg_we, cfg_addr, cfg_wdata, int_ack, eoi,
        input  cfg_rdata, INT, int_vec, int_id
    );
endinterface
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : int_ctrl
// Brief    : Edge-triggered, masked, fixed-priority interrupt controller.
//            Define INT_NESTED_EN to let higher-priority sources preempt.
// Revision : 1.0
// ============================================================================
module int_ctrl #(
    parameter int          NUM_SRC    = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int          VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_in,
    int_ctrl_if.master         bus
);

    localparam logic [1:0] c_ADDR_MASK   = 2'd0;
    localparam logic [1:0] c_ADDR_PEND   = 2'd1;
    localparam logic [1:0] c_ADDR_INSERV = 2'd2;
    localparam logic [1:0] c_ADDR_STATUS = 2'd3;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_REQ  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [NUM_SRC-1:0] r_irq_prev;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_inservice;
    logic [3:0]         r_int_id;
    logic [31:0]        r_int_vec;

    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_w1c;
    logic [NUM_SRC-1:0] w_mask_nxt;
    logic [NUM_SRC-1:0] w_pending_nxt;
    logic [NUM_SRC-1:0] w_inservice_nxt;
    logic [NUM_SRC-1:0] w_id_onehot;
    logic [NUM_SRC-1:0] w_ack_set;
    logic [NUM_SRC-1:0] w_eoi_clr;
    logic               w_ack_fire;
    logic               w_cand_vld;
    logic [3:0]         w_cand;
    logic               w_blocked;
    logic [31:0]        w_vec;
    logic               w_latch;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_unused = ^bus.cfg_wdata;

    // Register-port decode and next values of the tracking vectors
    always_comb begin
        w_edge      = irq_in & ~r_irq_prev;
        w_w1c       = '0;
        w_mask_nxt  = r_mask;
        if (bus.cfg_we && (bus.cfg_addr == c_ADDR_PEND)) begin
            w_w1c = bus.cfg_wdata[NUM_SRC-1:0];
        end
        if (bus.cfg_we && (bus.cfg_addr == c_ADDR_MASK)) begin
            w_mask_nxt = bus.cfg_wdata[NUM_SRC-1:0];
        end
        w_id_onehot = NUM_SRC'(1) << r_int_id;
        w_ack_fire  = (r_state == c_ST_REQ) && bus.int_ack;
        w_ack_set   = w_ack_fire ? w_id_onehot : '0;
        // Set wins over any clear in the same cycle
        w_pending_nxt = (r_pending & ~(w_w1c | w_ack_set)) | w_edge;
        // eoi retires the lowest set in-service bit of the pre-ack value
        w_eoi_clr = bus.eoi ? (r_inservice & (~r_inservice + NUM_SRC'(1))) : '0;
        w_inservice_nxt = (r_inservice & ~w_eoi_clr) | w_ack_set;
    end

    // Fixed-priority candidate and its eligibility against in-service state
    always_comb begin
        w_cand_vld = 1'b0;
        w_cand     = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (r_pending[i] && r_mask[i]) begin
                w_cand_vld = 1'b1;
                w_cand     = 4'(i);
            end
        end
        w_blocked = 1'b0;
`ifdef INT_NESTED_EN
        for (int j = 0; j < NUM_SRC; j++) begin
            if (r_inservice[j] && (4'(j) <= w_cand)) begin
                w_blocked = 1'b1;
            end
        end
`else
        w_blocked = |r_inservice;
`endif
        w_vec = VEC_BASE + (32'(w_cand) * 32'(VEC_STRIDE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Withdraw looks at next-cycle pending/mask so INT drops right after the write
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_cand_vld && !w_blocked) begin
                    w_state_nxt = c_ST_REQ;
                    w_latch     = 1'b1;
                end
            end
            c_ST_REQ: begin
                if (bus.int_ack) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (!(|(w_pending_nxt & w_mask_nxt & w_id_onehot))) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_prev  <= '0;
            r_mask      <= '0;
            r_pending   <= '0;
            r_inservice <= '0;
            r_int_id    <= 4'd0;
            r_int_vec   <= 32'd0;
        end else begin
            r_irq_prev  <= irq_in;
            r_mask      <= w_mask_nxt;
            r_pending   <= w_pending_nxt;
            r_inservice <= w_inservice_nxt;
            if (w_latch) begin
                r_int_id  <= w_cand;
                r_int_vec <= w_vec;
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (bus.cfg_addr)
            c_ADDR_MASK:   w_rdata[NUM_SRC-1:0] = r_mask;
            c_ADDR_PEND:   w_rdata[NUM_SRC-1:0] = r_pending;
            c_ADDR_INSERV: w_rdata[NUM_SRC-1:0] = r_inservice;
            c_ADDR_STATUS: w_rdata = {27'd0, (r_state == c_ST_REQ), r_int_id};
            default:       w_rdata = 32'd0;
        endcase
    end

    assign bus.cfg_rdata = w_rdata;
    assign bus.INT       = (r_state == c_ST_REQ);
    assign bus.int_id    = r_int_id;
    assign bus.int_vec   = r_int_vec;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_ctrl
// Brief    : Directed bench for int_ctrl; expected INT grants go to a queue
//            that a monitor pops on every rising INT.
// Revision : 1.0
// ============================================================================
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_in;

    int_ctrl_if bus ();

    int_ctrl #(
        .NUM_SRC    (8),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] vec;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic int_q    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic push(input logic [3:0] id, input logic [31:0] vec);
        exp_t e;
        e.id  = id;
        e.vec = vec;
        q.push_back(e);
    endtask

    // Monitor: every rising INT must match the oldest expected grant
    always @(negedge clk) begin
        exp_t e;
        if (bus.INT && !int_q) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_int: got id %0d, required no request", bus.int_id);
            end else begin
                e = q.pop_front();
                chk("int_id", {28'd0, bus.int_id}, {28'd0, e.id});
                chk("int_vec", bus.int_vec, e.vec);
            end
        end
        int_q = bus.INT;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        step(1);
        bus.cfg_we    = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
        bus.cfg_addr = a;
        #1;
        chk(name, bus.cfg_rdata, exp);
    endtask

    task automatic chk_int(input string name, input logic exp);
        chk(name, {31'd0, bus.INT}, {31'd0, exp});
    endtask

    task automatic ack();
        bus.int_ack = 1'b1;
        step(1);
        bus.int_ack = 1'b0;
    endtask

    task automatic do_eoi();
        bus.eoi = 1'b1;
        step(1);
        bus.eoi = 1'b0;
    endtask

    task automatic pulse(input int i);
        irq_in[i] = 1'b1;
        step(1);
        irq_in[i] = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        irq_in        = 8'h00;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 2'd0;
        bus.cfg_wdata = 32'd0;
        bus.int_ack   = 1'b0;
        bus.eoi       = 1'b0;
        step(3);
        chk_int("reset_int", 1'b0);
        chk("reset_id", {28'd0, bus.int_id}, 32'd0);
        chk("reset_vec", bus.int_vec, 32'd0);
        chk_reg("reset_mask", 2'd0, 32'd0);
        chk_reg("reset_status", 2'd3, 32'd0);
        rst = 1'b0;
        step(1);

        // Basic request on source 2
        wr(2'd0, 32'h04);
        push(4'd2, 32'h0000_0108);
        pulse(2);
        chk_int("basic_int_early", 1'b0);
        step(1);
        chk_int("basic_int", 1'b1);
        chk_reg("basic_status", 2'd3, 32'h12);
        ack();
        chk_int("basic_int_after_ack", 1'b0);
        chk_reg("basic_pending", 2'd1, 32'h00);
        chk_reg("basic_inservice", 2'd2, 32'h04);
        do_eoi();
        chk_reg("basic_inservice_eoi", 2'd2, 32'h00);

        // Priority: 1 and 5 together; 5 (lower priority) waits for eoi of 1
        wr(2'd0, 32'hFF);
        push(4'd1, 32'h0000_0104);
        irq_in = 8'h22;
        step(1);
        irq_in = 8'h00;
        step(1);
        chk_int("prio_int", 1'b1);
        ack();
        step(3);
        chk_int("prio_blocked", 1'b0);
        chk_reg("prio_pending", 2'd1, 32'h20);
        push(4'd5, 32'h0000_0114);
        do_eoi();
        chk_int("prio_eoi_idle", 1'b0);
        step(1);
        chk_int("prio_second_int", 1'b1);
        ack();
        do_eoi();
        chk_reg("prio_inservice", 2'd2, 32'h00);

        // Masked source becomes live when unmasked
        wr(2'd0, 32'h00);
        pulse(3);
        step(2);
        chk_reg("masked_pending", 2'd1, 32'h08);
        chk_int("masked_no_int", 1'b0);
        push(4'd3, 32'h0000_010C);
        wr(2'd0, 32'h08);
        chk_int("unmask_early", 1'b0);
        step(1);
        chk_int("unmask_int", 1'b1);
        ack();
        chk_reg("unmask_pending", 2'd1, 32'h00);
        do_eoi();

        // Withdraw by W1C before ack; later ack ignored
        wr(2'd0, 32'hFF);
        push(4'd4, 32'h0000_0110);
        pulse(4);
        step(1);
        chk_int("withdraw_int", 1'b1);
        wr(2'd1, 32'h10);
        chk_int("withdraw_dropped", 1'b0);
        step(1);
        ack();
        chk_reg("withdraw_inservice", 2'd2, 32'h00);
        step(2);
        chk_int("withdraw_stays_low", 1'b0);

        // Held level gives exactly one request
        push(4'd0, 32'h0000_0100);
        irq_in[0] = 1'b1;
        step(2);
        chk_int("held_int", 1'b1);
        ack();
        step(7);
        chk_int("held_no_repeat", 1'b0);
        chk_reg("held_pending", 2'd1, 32'h00);
        irq_in[0] = 1'b0;
        do_eoi();
        chk_reg("held_inservice", 2'd2, 32'h00);

        // Reset while INT is high, line still held
        push(4'd0, 32'h0000_0100);
        irq_in[0] = 1'b1;
        step(2);
        chk_int("rst_pre_int", 1'b1);
        rst = 1'b1;
        step(1);
        chk_int("rst_int", 1'b0);
        chk("rst_id", {28'd0, bus.int_id}, 32'd0);
        chk("rst_vec", bus.int_vec, 32'd0);
        chk_reg("rst_mask", 2'd0, 32'd0);
        chk_reg("rst_pending", 2'd1, 32'd0);
        chk_reg("rst_inservice", 2'd2, 32'd0);
        rst = 1'b0;
        step(1);
        chk_reg("rst_recapture", 2'd1, 32'h01);
        chk_int("rst_masked_low", 1'b0);
        push(4'd0, 32'h0000_0100);
        wr(2'd0, 32'h01);
        step(1);
        chk_int("rst_new_int", 1'b1);
        ack();
        irq_in[0] = 1'b0;
        do_eoi();

        // Source 6 in service, then source 2 arrives
        wr(2'd0, 32'hFF);
        push(4'd6, 32'h0000_0118);
        pulse(6);
        step(1);
        chk_int("nest_int6", 1'b1);
        ack();
        chk_reg("nest_inservice6", 2'd2, 32'h40);
`ifdef INT_NESTED_EN
        push(4'd2, 32'h0000_0108);
        pulse(2);
        step(1);
        chk_int("nest_int2", 1'b1);
        ack();
        chk_reg("nest_inservice44", 2'd2, 32'h44);
        do_eoi();
        chk_reg("nest_eoi1", 2'd2, 32'h40);
        do_eoi();
        chk_reg("nest_eoi2", 2'd2, 32'h00);
`else
        pulse(2);
        step(2);
        chk_int("nonest_blocked", 1'b0);
        push(4'd2, 32'h0000_0108);
        do_eoi();
        chk_reg("nonest_eoi", 2'd2, 32'h00);
        step(1);
        chk_int("nonest_int2", 1'b1);
        ack();
        chk_reg("nonest_inservice", 2'd2, 32'h04);
        do_eoi();
        chk_reg("nonest_final", 2'd2, 32'h00);
`endif

        step(2);
        chk("queue_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
